// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Op codes, FSM encoding and the operand magnitude helper.
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic [DATA_W-1:0] mag(
    input logic [DATA_W-1:0] x,
    input logic              sgn
  );
    return (sgn & x[DATA_W-1]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage to mul/div controller op/result bundle.
// master = pipeline side, slave = controller side.
interface muldiv_if;
  import muldiv_pkg::*;

  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              op_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output op_ready, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider datapath.
// Works on magnitudes; signs are reapplied combinationally during FIX.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              fix_i,
  input  logic              is_div_i,
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [63:0]       p_q, p_d;
  logic [DATA_W-1:0] b_q;
  logic              sa_q, sb_q;

  logic [32:0] sum33;
  logic [32:0] shl33;
  logic [32:0] diff33;
  logic        nonneg;

  // p holds {acc, multiplier} for mul and {rem, dividend/quot} for div
  always_comb begin
    sum33  = {1'b0, p_q[63:32]} + {1'b0, b_q};
    shl33  = {p_q[63:32], p_q[31]};
    diff33 = shl33 - {1'b0, b_q};
    nonneg = ~diff33[32];
    p_d    = p_q;
    if (load_i) begin
      p_d = {32'd0, mag(a_i, sgn_i)};
    end else if (step_i) begin
      if (is_div_i) begin
        p_d = {nonneg ? diff33[31:0] : shl33[31:0],
               p_q[30:0], nonneg};
      end else if (p_q[0]) begin
        p_d = {sum33, p_q[31:1]};
      end else begin
        p_d = {1'b0, p_q[63:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q  <= '0;
      b_q  <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else begin
      p_q <= p_d;
      if (load_i) begin
        b_q  <= mag(b_i, sgn_i);
        sa_q <= sgn_i & a_i[DATA_W-1];
        sb_q <= sgn_i & b_i[DATA_W-1];
      end
    end
  end

  logic              neg;
  logic [63:0]       prod;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  always_comb begin
    neg  = sa_q ^ sb_q;
    prod = neg ? (~p_q + 64'd1) : p_q;
    quo  = neg ? (~p_q[31:0] + 32'd1) : p_q[31:0];
    rem  = sa_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
    hi_o = is_div_i ? rem : prod[63:32];
    lo_o = is_div_i ? quo : prod[31:0];
    wr_o = fix_i & ~(is_div_i & (b_q == '0));
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: accepts mul/div/move ops, sequences muldiv_iter,
// stalls the pipeline via busy and pulses done when HI/LO are final.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  md
);

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              is_div_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              accept;
  logic              is_md;
  logic              it_wr;
  logic [DATA_W-1:0] it_hi;
  logic [DATA_W-1:0] it_lo;

  assign md.op_ready = (state_q == IDLE) & ~md.flush;
  assign accept      = md.op_valid & md.op_ready;
  assign is_md       = ~md.op[2];

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  muldiv_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept & is_md),
    .step_i   ((state_q == RUN) & ~md.flush),
    .fix_i    ((state_q == FIX) & ~md.flush),
    .is_div_i (is_div_q),
    .sgn_i    (~md.op[0]),
    .a_i      (md.src_a),
    .b_i      (md.src_b),
    .wr_o     (it_wr),
    .hi_o     (it_hi),
    .lo_o     (it_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_md: begin
                state_q  <= RUN;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                is_div_q <= md.op[1];
              end
              md.op == MD_MTHI: hi_q <= md.src_a;
              md.op == MD_MTLO: lo_q <= md.src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (md.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!md.flush) begin
            done_q <= 1'b1;
            if (it_wr) begin
              hi_q <= it_hi;
              lo_q <= it_lo;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide controller that owns the architectural HI/LO registers for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and sequences an iterative radix-2 shift-add multiplier and restoring divider. It raises a stall (busy) toward the pipeline until HI/LO are final. MFHI/MFLO read hi/lo directly once busy is low.

Parameters:
DATA_W, 32, operand and HI/LO width; the only supported value.
CNT_W, 5, iteration counter width; must equal log2(DATA_W).

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
op_valid  in  1  EX presents a mul/div/move op this cycle
op  in  3  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved
src_a  in  32  rs value
src_b  in  32  rt value
flush  in  1  exception/eret cancel of the in-flight op
op_ready  out  1  controller can accept an op this cycle
busy  out  1  mul/div in flight; pipeline stalls MFHI/MFLO and new mul/div ops
done  out  1  one-cycle pulse; HI/LO hold a new mul/div result this cycle
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset, asynchronous and active-high, forces the following values:
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Internal shift registers are cleared.
  - An op that is mid-run when reset asserts is discarded.
- FSM states and transitions:
  - IDLE -> RUN on accept of a mul/div op.
  - RUN -> FIX when the counter reaches 31.
  - FIX -> IDLE always.
  - RUN or FIX -> IDLE on flush.
- op_ready = (state==IDLE) & ~flush. This is combinational.
- An op is accepted when op_valid & op_ready. Ops presented while busy are ignored; the pipeline must hold them.
- MTHI/MTLO:
  - When accepted, src_a is written to hi or lo at the same edge.
  - The state stays IDLE; busy and done are not raised.
- Reserved op codes are accepted and have no effect.
- Operand capture at the accept edge:
  - Signed ops (MULT, DIV) capture the magnitudes of src_a and src_b plus the two sign bits.
  - Unsigned ops capture the operands raw.
- RUN: one iteration per cycle, counter 0..31, 32 cycles total.
  - MUL: 64-bit shift-add; add the multiplicand when the multiplier LSB is 1, then shift right.
  - DIV: restoring division; shift the remainder left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- FIX (1 cycle): sign correction, written to hi/lo at the FIX->IDLE edge.
  - MULT: the 64-bit product is negated if the operand signs differ.
  - DIV: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - {hi,lo} = product for mul; lo = quotient, hi = remainder for div.
- Latency, counting the accept edge as E0:
  - busy is high for 33 cycles (32 RUN + 1 FIX).
  - hi/lo update at E33.
  - done is high in the cycle after E33. op_ready is also high in that cycle, so back-to-back ops are allowed.
- Divide by zero (src_b==0 for DIV/DIVU): runs the full latency and pulses done, but hi/lo are not written.
- Overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. Arithmetic wraps; no trap.
- Flush:
  - Asserted in RUN or FIX: state goes to IDLE at the next edge, busy falls, hi/lo are not written, and done is not pulsed.
  - Asserted in IDLE: blocks acceptance in that cycle, including MTHI/MTLO.
- All arithmetic is unsigned on internal 33/64-bit registers; no operand width is extended beyond 64 bits.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op code constants (MD_MULT..MD_MTLO);
  - the FSM state encoding (IDLE, RUN, FIX);
  - DATA_W.
- One natural sub-module, muldiv_iter, holds the datapath: shift registers, adder/subtractor, magnitude/sign-fix logic. Its controls are load, step, fix, is_div.
- The FSM, counter, flush/accept handshake and HI/LO registers stay in muldiv_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high exactly 33 cycles; hi=0xFFFFFFFE, lo=0x00000001 at E33; done pulses one cycle.
- MULT 0xFFFFFFFD(-3)*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 0x1234 then DIVU 5/0 -> lo stays 0x1234, hi stays prior value, done pulses at E33+1.
- DIVU accepted, flush asserted in RUN cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged; a MULTU 3*4 presented the following cycle is accepted and yields lo=12.
- Reset asserted asynchronously mid-RUN:
  - hi/lo/busy go to 0 immediately, without waiting for a clock edge.
  - MTHI while busy -> op_ready=0 and hi unchanged.
  - op_valid with op=MTHI on the done cycle -> accepted.
